// File: rtl/div_sched_if.sv
// Request/result bundle between the execute stage and the shared divider controller.
interface div_sched_if #(
    parameter int unsigned DIV_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       div_op;
    logic [DIV_W-1:0] src1;
    logic [DIV_W-1:0] src2;
    logic             flush;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [DIV_W-1:0] res_lo;
    logic [DIV_W-1:0] res_hi;

    modport master (
        output req_valid, div_op, src1, src2, flush, res_ready,
        input  req_ready, busy, res_valid, res_lo, res_hi
    );

    modport slave (
        input  req_valid, div_op, src1, src2, flush, res_ready,
        output req_ready, busy, res_valid, res_lo, res_hi
    );
endinterface

// File: rtl/div_sched.sv
// Controller for the shared restoring radix-2 divider (DIV/DIVU): one request at a time,
// prepare / DIV_W iterations / sign fix-up, result held until the execute stage consumes it.
module div_sched #(
    parameter int unsigned DIV_W = 32
) (
    input logic        clk,
    input logic        reset,
    div_sched_if.slave bus
);
    localparam int unsigned CW = $clog2(DIV_W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] a_q, a_d, b_q, b_d, dvs_q, dvs_d;
    logic [DIV_W-1:0] rem_q, rem_d, quo_q, quo_d, lo_q, lo_d, hi_q, hi_d;
    logic             sgn_q, sgn_d, sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DIV_W:0]   shifted, trial;
    logic             op_ok;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        sgn_d   = sgn_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        shifted = {rem_q, quo_q[DIV_W-1]};
        trial   = shifted - {1'b0, dvs_q};
        op_ok   = (bus.div_op == 2'b01) || (bus.div_op == 2'b10);

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && !bus.flush && op_ok) begin
                    a_d     = bus.src1;
                    b_d     = bus.src2;
                    sgn_d   = (bus.div_op == 2'b01);
                    sa_d    = bus.src1[DIV_W-1];
                    sb_d    = bus.src2[DIV_W-1];
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                quo_d   = (sgn_q && sa_q) ? -a_q : a_q;
                dvs_d   = (sgn_q && sb_q) ? -b_q : b_q;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                // rem < divisor, so the DIV_W+1-bit trial never overflows and its MSB is the sign
                if (trial[DIV_W]) begin
                    rem_d = shifted[DIV_W-1:0];
                    quo_d = {quo_q[DIV_W-2:0], 1'b0};
                end else begin
                    rem_d = trial[DIV_W-1:0];
                    quo_d = {quo_q[DIV_W-2:0], 1'b1};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DIV_W - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (b_q == '0) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = (sgn_q && (sa_q ^ sb_q)) ? -quo_q : quo_q;
                    hi_d = (sgn_q && sa_q) ? -rem_q : rem_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything outside IDLE and leaves the held result untouched
        if (bus.flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            lo_d    = lo_q;
            hi_d    = hi_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            sgn_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            sgn_q   <= sgn_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.res_valid = (state_q == S_DONE);
    assign bus.res_lo    = lo_q;
    assign bus.res_hi    = hi_q;
endmodule

// File: doc/div_sched.md
Name: div_sched

Overview:
- Scheduler/controller for the shared iterative divider used by DIV/DIVU in the execute stage.
- Accepts one request at a time over a valid/ready handshake and sequences a restoring radix-2 shift-subtract datapath through prepare, iterate and fix-up phases.
- Holds the quotient (LO) and remainder (HI) until the execute stage consumes them.
- Flush abandons the operation in flight.

Parameters:
- DIV_W, 32, operand/result width; iteration count equals DIV_W.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  execute stage presents a divide
- req_ready  output  1  controller can accept a request (state IDLE)
- div_op  input  2  bit0 = signed div, bit1 = unsigned divu (same encoding as the decode bus)
- src1  input  DIV_W  dividend (rs value)
- src2  input  DIV_W  divisor (rt value)
- flush  input  1  discard the current operation
- busy  output  1  state is not IDLE
- res_valid  output  1  result available (state DONE)
- res_ready  input  1  execute stage consumes the result
- res_lo  output  DIV_W  quotient
- res_hi  output  DIV_W  remainder

Behaviour:
- Reset (async) → state IDLE, iteration counter 0, all internal registers 0. Output values during reset: req_ready=1, busy=0, res_valid=0, res_lo=0, res_hi=0.
- Accept condition: req_valid && req_ready && !flush && div_op is 2'b01 or 2'b10. On the accepting edge, latch src1, src2, the signed flag, and the sign bits of both operands.
- div_op 2'b00 or 2'b11: never accepted; no state change.
- States:
  - IDLE: req_ready=1. Accept → PREP.
  - PREP (1 cycle): take absolute values if signed, else raw. Clear the partial remainder. Load dividend into the quotient shift register. Counter=0. → CALC.
  - CALC (DIV_W cycles), per cycle:
    - shift {rem, quo} left by 1;
    - trial = rem_shifted − divisor (DIV_W+1 bits);
    - if trial ≥ 0: rem = trial and quo LSB = 1; else quo LSB = 0;
    - counter++.
    - After counter == DIV_W−1 → FIX.
  - FIX (1 cycle): if signed, negate the quotient when the operand signs differ, and negate the remainder when the dividend is negative. Register the final results. → DONE.
  - DONE: res_valid=1, results stable. res_ready → IDLE on that edge. req_ready=0 in DONE, so there is no same-edge re-accept.
- Latency: res_valid first high after the 34th rising edge following the accepting edge (PREP 1 + CALC 32 + FIX 1). Latency is fixed and independent of operand values.
- res_lo/res_hi hold their last result in IDLE. They update only on exit from FIX.
- Divide by zero (src2==0), both ops, same latency:
  - res_lo = all ones;
  - res_hi = original src1;
  - the FIX sign correction is skipped for this case.
- Signed overflow 0x80000000 / 0xFFFFFFFF: res_lo=0x80000000, res_hi=0. This falls out of the absolute-value path with no special case.
- Flush:
  - In any non-IDLE state: next edge → IDLE; res_valid low from that edge; result registers unchanged.
  - In IDLE: blocks acceptance.
  - Flush and res_ready together in DONE: → IDLE; treated as consumed.
- Async reset mid-operation: immediate return to IDLE; no result is produced.
- busy = (state != IDLE). The execute stage stalls its ready_go on busy or on a pending request.
- Widths: all arithmetic is DIV_W bits except the DIV_W+1-bit trial subtraction. The counter is clog2(DIV_W)+1 bits.

Test Plan:
- divu, src1=100, src2=7, res_ready=1 → res_lo=14, res_hi=2. res_valid is high exactly 34 edges after the accept, for one cycle. req_ready is low throughout.
- div, src1=0xFFFFFFF9 (−7), src2=2 → res_lo=0xFFFFFFFD (−3), res_hi=0xFFFFFFFF (−1). The same operands under divu → res_lo=0x7FFFFFFC, res_hi=1.
- div, src1=0x80000000, src2=0xFFFFFFFF → res_lo=0x80000000, res_hi=0. Then divu 5/0 → res_lo=0xFFFFFFFF, res_hi=5, same latency.
- Backpressure: complete divu 9/3, then hold res_ready=0 for 10 cycles → res_valid stays 1, res_lo=3 and res_hi=0 stable, req_ready=0 with req_valid held. Raise res_ready → IDLE next edge; the pending request is accepted the following cycle.
- Flush: assert flush for 1 cycle at CALC iteration 10 → state IDLE next edge, res_valid never rises, res_lo/res_hi retain the previous result. A new divu 50/5 then gives res_lo=10, res_hi=0.
- Assert reset asynchronously mid-CALC (between edges) → req_ready=1, busy=0, res_valid=0, res_lo=res_hi=0 immediately. Deassert reset; a new request completes normally. Also drive div_op=2'b11 with req_valid → never accepted, busy stays 0.
